// File: rtl/rv32i_pkg.sv
// Shared RV32I decode encodings and the ID/EX stage bundle used by the pipeline registers.
// Holds the RF_sel/ALU_op encodings, the bubble constant and a helper that builds a bubble.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] RF_SEL_ALU     = 3'b000;
  localparam logic [2:0] RF_SEL_UIMM    = 3'b010;
  localparam logic [2:0] RF_SEL_PC4     = 3'b011;
  localparam logic [2:0] RF_SEL_PC_UIMM = 3'b100;
  localparam logic [2:0] RF_SEL_ZERO    = 3'b101;
  localparam logic [2:0] RF_SEL_ONES    = 3'b110;

  localparam logic [2:0] BUBBLE_RF_SEL  = RF_SEL_ZERO;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_4;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      rf_sel;
    logic [3:0]      alu_op;
    logic            we_reg;
    logic            we_mem;
    logic            is_load;
  } idex_t;

  // Bubble: no side effects and no register indices, so nothing downstream can match it.
  function automatic idex_t idex_bubble();
    idex_t b;
    b        = '0;
    b.rf_sel = BUBBLE_RF_SEL;
    return b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts enabled cycles, holds at all-ones, sync active-high reset.
// One cycle from i_inc to o_cnt; o_cnt is a pure register output.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: one-cycle copy of decode outputs, bubble on flush/stall/invalid.
// Flush outranks stall; stall and flush events are tallied by saturating counters.
module id_ex_pipe
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_ID,
  input  logic [31:0] PC_ID,
  input  logic [31:0] PC_4_ID,
  input  logic [31:0] U_imm_ID,
  input  logic [31:0] rs1_data_ID,
  input  logic [31:0] rs2_data_ID,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [4:0]  rd_ID,
  input  logic [2:0]  RF_sel_ID,
  input  logic [3:0]  ALU_op_ID,
  input  logic        we_reg_ID,
  input  logic        we_mem_ID,
  input  logic        is_load_ID,
  output logic        valid_EX,
  output logic [31:0] PC_EX,
  output logic [31:0] PC_4_EX,
  output logic [31:0] U_imm_EX,
  output logic [31:0] rs1_data_EX,
  output logic [31:0] rs2_data_EX,
  output logic [4:0]  rs1_EX,
  output logic [4:0]  rs2_EX,
  output logic [4:0]  rd_EX,
  output logic [2:0]  RF_sel_EX,
  output logic [3:0]  ALU_op_EX,
  output logic        we_reg_EX,
  output logic        we_mem_EX,
  output logic        is_load_EX,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  idex_t r_ex;
  idex_t w_id;
  logic  w_bubble;
  logic  w_stall_inc;

  always_comb begin
    w_id          = '0;
    w_id.valid    = 1'b1;
    w_id.pc       = PC_ID;
    w_id.pc_4     = PC_4_ID;
    w_id.u_imm    = U_imm_ID;
    w_id.rs1_data = rs1_data_ID;
    w_id.rs2_data = rs2_data_ID;
    w_id.rs1      = rs1_ID;
    w_id.rs2      = rs2_ID;
    w_id.rd       = rd_ID;
    w_id.rf_sel   = RF_sel_ID;
    w_id.alu_op   = ALU_op_ID;
    w_id.we_reg   = we_reg_ID;
    w_id.we_mem   = we_mem_ID;
    w_id.is_load  = is_load_ID;
  end

  assign w_bubble = flush || stall || !valid_ID;

  // Reset state and bubble state are the same value.
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ex <= idex_bubble();
    end else begin
      r_ex <= w_id;
    end
  end

  assign valid_EX    = r_ex.valid;
  assign PC_EX       = r_ex.pc;
  assign PC_4_EX     = r_ex.pc_4;
  assign U_imm_EX    = r_ex.u_imm;
  assign rs1_data_EX = r_ex.rs1_data;
  assign rs2_data_EX = r_ex.rs2_data;
  assign rs1_EX      = r_ex.rs1;
  assign rs2_EX      = r_ex.rs2;
  assign rd_EX       = r_ex.rd;
  assign RF_sel_EX   = r_ex.rf_sel;
  assign ALU_op_EX   = r_ex.alu_op;
  assign we_reg_EX   = r_ex.we_reg;
  assign we_mem_EX   = r_ex.we_mem;
  assign is_load_EX  = r_ex.is_load;

  // A stall hidden behind a simultaneous flush is not a stall event.
  assign w_stall_inc = stall && !flush;

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (flush),
    .o_cnt (flush_cnt)
  );

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  load-use hazard from forwarding unit; insert bubble into EX.
- flush  in  1  taken branch/jump resolved in EX; kill instruction in ID.
- valid_ID  in  1  ID slot holds a real instruction.
- PC_ID, PC_4_ID, U_imm_ID  in  32 each  PC, PC+4, decoded immediate.
- rs1_data_ID, rs2_data_ID  in  32 each  register-file read data.
- rs1_ID, rs2_ID, rd_ID  in  5 each  register indices.
- RF_sel_ID  in  3  writeback source select.
- ALU_op_ID  in  4  ALU operation.
- we_reg_ID, we_mem_ID, is_load_ID  in  1 each  control bits.
- all of the above with suffix _EX  out  same widths  registered EX-stage copies; plus valid_EX  out  1.
- stall_cnt, flush_cnt  out  32 each  saturating event counters.

Function
REQ-002 SHALL register every _ID input to its _EX output with exactly one cycle latency when rst=0, stall=0, flush=0, valid_ID=1.
REQ-003 SHALL load a bubble when flush=1, or stall=1, or valid_ID=0: valid_EX=0, we_reg_EX=0, we_mem_EX=0, is_load_EX=0, rd_EX=0, rs1_EX=0, rs2_EX=0, RF_sel_EX=3'b101; data/PC fields unspecified (implementation keeps them 0).
REQ-004 SHALL give flush priority over stall when both are 1 in the same cycle; result is one bubble.
REQ-005 SHALL make stall exactly one bubble per asserted cycle; since bubble forces is_load_EX=0, a single load-use hazard produces a single bubble.
REQ-006 SHALL zero rs1_EX/rs2_EX/rd_EX in bubbles so no downstream forwarding or hazard match occurs on a bubble.
REQ-007 SHALL increment stall_cnt on each cycle with stall=1 and flush=0 and rst=0.
REQ-008 SHALL increment flush_cnt on each cycle with flush=1 and rst=0, regardless of stall.
REQ-009 SHALL saturate both counters at 32'hFFFFFFFF (no wrap).
REQ-010 SHALL not gate any _EX update on valid_ID for counters (valid_ID=0 alone counts nothing).
REQ-011 SHALL contain no combinational path from any input to any output.

Reset
REQ-012 SHALL, on rst=1 at a rising edge, load the bubble state of REQ-003 with all data/PC fields 0 and both counters 0.
REQ-013 SHALL let rst override stall and flush, including mid-stall; first post-reset valid instruction appears in EX one cycle after being presented.

Structure
REQ-014 SHALL take RF_sel encodings (000 ALU, 010 U_imm, 011 PC+4, 100 PC+U_imm, 101 zero, 110 all-ones), ALU_op encodings and the bubble constant from shared package rv32i_pkg.
REQ-015 SHALL implement both counters via one sub-module sat_counter (32-bit, inc enable, sync reset).

Verification
REQ-016 Pass-through: valid_ID=1, PC_ID=32'h100, rd_ID=5, we_reg_ID=1 -> next cycle PC_EX=32'h100, rd_EX=5, we_reg_EX=1, valid_EX=1.
REQ-017 Load-use: is_load_ID=1, rd_ID=7 then dependent instr with stall=1 for one cycle -> one bubble (valid_EX=0, rd_EX=0), stall_cnt=1, dependent instr in EX the cycle after.
REQ-018 Stall+flush same cycle -> bubble, flush_cnt=1, stall_cnt=0.
REQ-019 Saturation: force stall_cnt to 32'hFFFFFFFE, assert stall 3 cycles -> stall_cnt=32'hFFFFFFFF and stays.
REQ-020 Reset mid-operation: rst=1 while stall=1 and flush=1 with counters at 9 -> valid_EX=0, all _EX fields 0, RF_sel_EX=3'b101, counters 0 next cycle.
REQ-021 valid_ID=0 with stall=0, flush=0 -> bubble, counters unchanged.
